// File: rtl/tank_pkg.sv
// Shared types, default key codes and sign-magnitude helper
// for the per-player tank motion controller.
package tank_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_BACKOFF = 2'd1,
        ST_DEAD    = 2'd2,
        ST_FROZEN  = 2'd3
    } tank_state_e;

    typedef struct packed {
        logic up;
        logic dn;
        logic cw;
        logic ccw;
        logic fire;
    } tank_keys_t;

    localparam logic [7:0] KEY_UP_DEF   = 8'h52;
    localparam logic [7:0] KEY_DN_DEF   = 8'h51;
    localparam logic [7:0] KEY_CW_DEF   = 8'h50;
    localparam logic [7:0] KEY_CCW_DEF  = 8'h4F;
    localparam logic [7:0] KEY_FIRE_DEF = 8'h2C;

    // Magnitude is scaled by speed/16 before the sign is applied so that
    // positive and negative headings give steps of identical size.
    function automatic int sm_to_signed(input logic [7:0] sm,
                                        input int         speed);
        int mag;
        mag = (speed * int'(sm[6:0])) >>> 4;
        return sm[7] ? -mag : mag;
    endfunction

endpackage

// File: rtl/tank_key_decode.sv
// Scans the keycode slots and reports the held control keys,
// with move/rotate already resolved by priority.
module tank_key_decode
    import tank_pkg::*;
#(
    parameter int         NUM_KEYS = 4,
    parameter logic [7:0] KEY_UP   = KEY_UP_DEF,
    parameter logic [7:0] KEY_DN   = KEY_DN_DEF,
    parameter logic [7:0] KEY_CW   = KEY_CW_DEF,
    parameter logic [7:0] KEY_CCW  = KEY_CCW_DEF,
    parameter logic [7:0] KEY_FIRE = KEY_FIRE_DEF
) (
    input  logic [8*NUM_KEYS-1:0] keycode_i,
    output tank_keys_t            keys_o
);

    logic       up_raw;
    logic       dn_raw;
    logic       cw_raw;
    logic       ccw_raw;
    logic       fire_raw;
    logic [7:0] slot;

    always_comb begin
        up_raw   = 1'b0;
        dn_raw   = 1'b0;
        cw_raw   = 1'b0;
        ccw_raw  = 1'b0;
        fire_raw = 1'b0;
        slot     = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            slot     = keycode_i[8*i +: 8];
            up_raw   = up_raw   | (slot == KEY_UP);
            dn_raw   = dn_raw   | (slot == KEY_DN);
            cw_raw   = cw_raw   | (slot == KEY_CW);
            ccw_raw  = ccw_raw  | (slot == KEY_CCW);
            fire_raw = fire_raw | (slot == KEY_FIRE);
        end
    end

    // Fire is orthogonal to motion; only the motion keys are prioritised.
    always_comb begin
        keys_o      = '0;
        keys_o.fire = fire_raw;
        priority case (1'b1)
            up_raw:  keys_o.up  = 1'b1;
            dn_raw:  keys_o.dn  = 1'b1;
            cw_raw:  keys_o.cw  = 1'b1;
            ccw_raw: keys_o.ccw = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/tank_motion_ctrl.sv
// Per-player tank controller: key decode, heading-driven motion,
// wall back-off, fire cooldown and hit/respawn/freeze sequencing.
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter int         NUM_KEYS    = 4,
    parameter int         FRAC_BITS   = 3,
    parameter int         POS_W       = 13,
    parameter int         SPEED       = 16,
    parameter int         ANGLE_STEPS = 45,
    parameter int         X_MAX       = 639,
    parameter int         Y_MAX       = 479,
    parameter int         FIRE_CD     = 30,
    parameter int         RESPAWN_FR  = 60,
    parameter logic [7:0] KEY_UP      = KEY_UP_DEF,
    parameter logic [7:0] KEY_DN      = KEY_DN_DEF,
    parameter logic [7:0] KEY_CW      = KEY_CW_DEF,
    parameter logic [7:0] KEY_CCW     = KEY_CCW_DEF,
    parameter logic [7:0] KEY_FIRE    = KEY_FIRE_DEF,
    localparam int        ANGLE_W     = $clog2(ANGLE_STEPS)
) (
    input  logic                    frame_clk_i,
    input  logic                    reset_i,
    input  logic [8*NUM_KEYS-1:0]   keycode_i,
    input  logic [7:0]              sin_i,
    input  logic [7:0]              cos_i,
    input  logic [3:0]              wall_hit_i,
    input  logic                    hit_i,
    input  logic [1:0]              game_end_i,
    input  logic [9:0]              spawn_x_i,
    input  logic [9:0]              spawn_y_i,
    output logic [9:0]              tank_x_o,
    output logic [9:0]              tank_y_o,
    output logic signed [POS_W-1:0] tank_x_step_o,
    output logic signed [POS_W-1:0] tank_y_step_o,
    output logic [ANGLE_W-1:0]      angle_o,
    output logic                    fire_o,
    output logic                    alive_o
);

    localparam int CD_W   = $clog2(FIRE_CD + 1);
    localparam int RESP_W = $clog2(RESPAWN_FR + 1);

    localparam logic [POS_W-1:0]   X_LIM      = POS_W'(X_MAX << FRAC_BITS);
    localparam logic [POS_W-1:0]   Y_LIM      = POS_W'(Y_MAX << FRAC_BITS);
    localparam logic [ANGLE_W-1:0] ANGLE_LAST = ANGLE_W'(ANGLE_STEPS - 1);
    localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(FIRE_CD);
    localparam logic [RESP_W-1:0]  RESP_LOAD  = RESP_W'(RESPAWN_FR);

    tank_state_e             state_q;
    tank_state_e             state_d;
    logic [POS_W-1:0]        pos_x_q;
    logic [POS_W-1:0]        pos_x_d;
    logic [POS_W-1:0]        pos_y_q;
    logic [POS_W-1:0]        pos_y_d;
    logic signed [POS_W-1:0] step_x_q;
    logic signed [POS_W-1:0] step_x_d;
    logic signed [POS_W-1:0] step_y_q;
    logic signed [POS_W-1:0] step_y_d;
    logic [ANGLE_W-1:0]      angle_q;
    logic [ANGLE_W-1:0]      angle_d;
    logic [CD_W-1:0]         cd_q;
    logic [CD_W-1:0]         cd_d;
    logic [RESP_W-1:0]       resp_q;
    logic [RESP_W-1:0]       resp_d;
    logic                    fire_q;
    logic                    fire_d;
    logic                    alive_q;
    logic                    alive_d;
    logic                    fire_key_q;

    tank_keys_t              keys;
    logic signed [POS_W-1:0] dx;
    logic signed [POS_W-1:0] dy;
    logic [POS_W-1:0]        spawn_x_fp;
    logic [POS_W-1:0]        spawn_y_fp;
    logic                    fire_ok;
    logic                    can_backoff;

    tank_key_decode #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_UP   (KEY_UP),
        .KEY_DN   (KEY_DN),
        .KEY_CW   (KEY_CW),
        .KEY_CCW  (KEY_CCW),
        .KEY_FIRE (KEY_FIRE)
    ) u_decode (
        .keycode_i (keycode_i),
        .keys_o    (keys)
    );

    // Clamp against both screen edges without ever wrapping.
    function automatic logic [POS_W-1:0] sat_add(
        input logic [POS_W-1:0]        pos,
        input logic signed [POS_W-1:0] step,
        input logic [POS_W-1:0]        lim
    );
        logic signed [POS_W+1:0] sum;
        sum = $signed({2'b00, pos}) + (POS_W+2)'(step);
        if (sum < 0) begin
            return '0;
        end
        if (sum > $signed({2'b00, lim})) begin
            return lim;
        end
        return sum[POS_W-1:0];
    endfunction

    assign dx         = POS_W'(sm_to_signed(cos_i, SPEED));
    assign dy         = POS_W'(sm_to_signed(sin_i, SPEED));
    assign spawn_x_fp = POS_W'(spawn_x_i) << FRAC_BITS;
    assign spawn_y_fp = POS_W'(spawn_y_i) << FRAC_BITS;

    assign fire_ok     = keys.fire && !fire_key_q && (cd_q == '0);
    assign can_backoff = (state_q == ST_ALIVE) && (wall_hit_i != '0)
                       && ((step_x_q != '0) || (step_y_q != '0));

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        step_x_d = '0;
        step_y_d = '0;
        angle_d  = angle_q;
        cd_d     = (cd_q != '0) ? cd_q - 1'b1 : '0;
        resp_d   = resp_q;
        fire_d   = 1'b0;
        alive_d  = alive_q;
        if (game_end_i != '0) begin
            state_d = ST_FROZEN;
            pos_x_d = spawn_x_fp;
            pos_y_d = spawn_y_fp;
            angle_d = '0;
            cd_d    = '0;
            alive_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_FROZEN: begin
                    state_d = ST_ALIVE;
                    alive_d = 1'b1;
                end
                ST_DEAD: begin
                    resp_d = resp_q - 1'b1;
                    if (resp_d == '0) begin
                        state_d = ST_ALIVE;
                        pos_x_d = spawn_x_fp;
                        pos_y_d = spawn_y_fp;
                        angle_d = '0;
                        cd_d    = '0;
                        alive_d = 1'b1;
                    end
                end
                ST_ALIVE, ST_BACKOFF: begin
                    if ((state_q == ST_ALIVE) && hit_i) begin
                        state_d = ST_DEAD;
                        resp_d  = RESP_LOAD;
                        alive_d = 1'b0;
                    end else begin
                        if (fire_ok) begin
                            fire_d = 1'b1;
                            cd_d   = CD_LOAD;
                        end
                        if (can_backoff) begin
                            state_d  = ST_BACKOFF;
                            step_x_d = -(step_x_q <<< 1);
                            step_y_d = -(step_y_q <<< 1);
                        end else begin
                            state_d = ST_ALIVE;
                            if (keys.up) begin
                                step_x_d = dx;
                                step_y_d = -dy;
                            end else if (keys.dn) begin
                                step_x_d = -dx;
                                step_y_d = dy;
                            end else if (state_q == ST_ALIVE) begin
                                if (keys.cw) begin
                                    angle_d = (angle_q == ANGLE_LAST)
                                            ? '0 : angle_q + 1'b1;
                                end else if (keys.ccw) begin
                                    angle_d = (angle_q == '0)
                                            ? ANGLE_LAST : angle_q - 1'b1;
                                end
                            end
                        end
                        pos_x_d = sat_add(pos_x_q, step_x_d, X_LIM);
                        pos_y_d = sat_add(pos_y_q, step_y_d, Y_LIM);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge frame_clk_i) begin
        if (reset_i) begin
            state_q    <= ST_ALIVE;
            pos_x_q    <= spawn_x_fp;
            pos_y_q    <= spawn_y_fp;
            step_x_q   <= '0;
            step_y_q   <= '0;
            angle_q    <= '0;
            cd_q       <= '0;
            resp_q     <= '0;
            fire_q     <= 1'b0;
            alive_q    <= 1'b1;
            fire_key_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            step_x_q   <= step_x_d;
            step_y_q   <= step_y_d;
            angle_q    <= angle_d;
            cd_q       <= cd_d;
            resp_q     <= resp_d;
            fire_q     <= fire_d;
            alive_q    <= alive_d;
            fire_key_q <= keys.fire;
        end
    end

    assign tank_x_o      = 10'(pos_x_q >> FRAC_BITS);
    assign tank_y_o      = 10'(pos_y_q >> FRAC_BITS);
    assign tank_x_step_o = step_x_q;
    assign tank_y_step_o = step_y_q;
    assign angle_o       = angle_q;
    assign fire_o        = fire_q;
    assign alive_o       = alive_q;

endmodule
